// File: rtl/sdram_refresh_scheduler.sv
// Purpose : shares the SDRAM between arbiter traffic and auto-refresh; counts refresh
//           intervals, keeps a saturating refresh debt, and issues refreshes when idle or urgent.
// Latency : ctl_req/arb_ack/ref_req decode combinationally from state (zero added latency).
// Backpressure: arbiter requests are held upstream (ctl_req forced to 0) during refresh or bursts.
//
// Ports
//   i_clk, i_rst_n     : clock; asynchronous active-low reset, shared with the controller
//   i_arb_req[2:0]     : one-hot (or zero) request vector from the arbiter
//   o_arb_ack          : acceptance returned to the arbiter (controller ack while IDLE)
//   o_ctl_req[2:0]     : gated request vector to the controller
//   i_ctl_ack          : controller accepted o_ctl_req
//   i_ctl_complete     : controller finished the accepted transaction, burst included
//   o_ref_req          : auto-refresh command request
//   i_ref_ack          : controller accepted the refresh command
//   i_ref_done         : refresh finished (tRFC elapsed), one-cycle pulse
//   o_debt[3:0]        : outstanding refresh count, 0..MAX_DEBT
//   o_overflow         : sticky, a credit arrived while debt was saturated

module sdram_refresh_scheduler #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int MAX_DEBT         = 8,
  parameter int URGENT_DEBT      = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_arb_req,
  output logic       o_arb_ack,
  output logic [2:0] o_ctl_req,
  input  logic       i_ctl_ack,
  input  logic       i_ctl_complete,
  output logic       o_ref_req,
  input  logic       i_ref_ack,
  input  logic       i_ref_done,
  output logic [3:0] o_debt,
  output logic       o_overflow
);

  localparam int            CW        = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CW-1:0] LP_RELOAD = CW'(REFRESH_INTERVAL - 1);
  localparam logic [CW-1:0] LP_ONE    = CW'(1);
  localparam logic [3:0]    LP_MAX    = 4'(MAX_DEBT);
  localparam logic [3:0]    LP_URGENT = 4'(URGENT_DEBT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_XFER     = 2'd1,
    S_REF_WAIT = 2'd2,
    S_REF_BUSY = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_debt;
  logic [3:0]    w_debt_nxt;
  logic          r_overflow;
  logic          w_ovf_set;
  logic          w_credit;
  logic          w_urgent;
  logic          w_ref_fire;
  logic          w_arb_any;

  // ---------------------------------------------------------------------------
  // Interval counter: free-running, independent of the FSM. The credit pulse is
  // the cycle in which the counter sits at zero.
  // ---------------------------------------------------------------------------
  assign w_credit = (r_cnt == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= LP_RELOAD;
    end else if (w_credit) begin
      r_cnt <= LP_RELOAD;
    end else begin
      r_cnt <= r_cnt - LP_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Refresh debt. A credit and an accepted refresh in the same cycle cancel.
  // A credit that cannot be counted because debt is saturated is recorded in
  // the sticky overflow flag, which only reset clears.
  // ---------------------------------------------------------------------------
  assign w_ref_fire = (r_state == S_REF_WAIT) && i_ref_ack;
  assign w_urgent   = (r_debt >= LP_URGENT);

  always_comb begin
    w_debt_nxt = r_debt;
    w_ovf_set  = 1'b0;
    case ({w_credit, w_ref_fire})
      2'b10: begin
        if (r_debt == LP_MAX) begin
          w_ovf_set = 1'b1;
        end else begin
          w_debt_nxt = r_debt + 4'd1;
        end
      end
      // REF_WAIT is only entered with debt != 0 and nothing else lowers debt,
      // so this decrement cannot wrap.
      2'b01:   w_debt_nxt = r_debt - 4'd1;
      default: w_debt_nxt = r_debt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_debt     <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      r_debt <= w_debt_nxt;
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_debt     = r_debt;
  assign o_overflow = r_overflow;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_arb_any = |i_arb_req;

  always_comb begin
    w_state_nxt = r_state;
    o_ctl_req   = 3'b000;
    o_arb_ack   = 1'b0;
    o_ref_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Urgent debt masks the client so the controller never sees a request
        // that the FSM is about to abandon in favour of a refresh.
        if (!w_urgent) begin
          o_ctl_req = i_arb_req;
        end
        o_arb_ack = i_ctl_ack;
        if (w_urgent) begin
          w_state_nxt = S_REF_WAIT;
        end else if (w_arb_any && i_ctl_ack) begin
          // A transaction that completes in its accept cycle never visits XFER.
          w_state_nxt = i_ctl_complete ? S_IDLE : S_XFER;
        end else if (!w_arb_any && (r_debt != 4'd0)) begin
          w_state_nxt = S_REF_WAIT;
        end
      end
      S_XFER: begin
        // Bursts run to completion; refresh waits even if debt turns urgent.
        if (i_ctl_complete) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REF_WAIT: begin
        o_ref_req = 1'b1;
        if (i_ref_ack) begin
          w_state_nxt = S_REF_BUSY;
        end
      end
      S_REF_BUSY: begin
        if (i_ref_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
  a_debt_bounded : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    r_debt <= LP_MAX);
  a_req_exclusive : assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_ref_req && (o_ctl_req != 3'b000)));

endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
module tb_sdram_refresh_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] arb_req = 3'b000;
  logic       arb_ack;
  logic [2:0] ctl_req;
  logic       ctl_ack = 1'b0;
  logic       ctl_complete = 1'b0;
  logic       ref_req;
  logic       ref_ack = 1'b0;
  logic       ref_done = 1'b0;
  logic [3:0] debt;
  logic       overflow;

  always #5 clk = ~clk;

  sdram_refresh_scheduler #(
    .REFRESH_INTERVAL(16),
    .MAX_DEBT        (8),
    .URGENT_DEBT     (4)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_arb_req     (arb_req),
    .o_arb_ack     (arb_ack),
    .o_ctl_req     (ctl_req),
    .i_ctl_ack     (ctl_ack),
    .i_ctl_complete(ctl_complete),
    .o_ref_req     (ref_req),
    .i_ref_ack     (ref_ack),
    .i_ref_done    (ref_done),
    .o_debt        (debt),
    .o_overflow    (overflow)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit auto_ref = 1'b0;
  bit auto_cli = 1'b0;
  int burst_cnt = 0;

  typedef struct packed {
    logic [2:0] arb;
    logic       ack;
    logic       cpl;
    logic [2:0] e_ctl;
    logic       e_aack;
    logic       e_ref;
    logic [3:0] e_debt;
  } vec_t;

  vec_t vt [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock. Optional responders: refresh (ack always, done one cycle after
  // the accepted request) and a client issuing 100-cycle bursts back to back.
  task automatic tick();
    logic fire;
    logic grant;
    logic was_cpl;
    fire    = ref_req & ref_ack;
    grant   = arb_ack;
    was_cpl = ctl_complete;
    @(posedge clk);
    #1;
    cyc++;
    if (auto_ref) begin
      ref_ack  = 1'b1;
      ref_done = fire;
    end
    if (auto_cli) begin
      if (was_cpl)             burst_cnt = 0;
      else if (grant)          burst_cnt = 1;
      else if (burst_cnt != 0) burst_cnt++;
      ctl_complete = (burst_cnt == 100);
      ctl_ack      = |ctl_req;
    end
    #1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    arb_req = 3'b000; ctl_ack = 1'b0; ctl_complete = 1'b0;
    ref_ack = 1'b0; ref_done = 1'b0;
    auto_ref = 1'b0; auto_cli = 1'b0; burst_cnt = 0;
    #1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    #1;
  endtask

  initial begin
    int grants;
    int refs;
    int maxd;
    bit ref_since;
    bit drained;

    // arb, ack, cpl, exp ctl_req, exp arb_ack, exp ref_req, exp debt
    vt[0]  = {3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 4'd0};
    vt[1]  = {3'b010, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 4'd0};
    vt[2]  = {3'b010, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 4'd0};
    for (int i = 3; i <= 9; i++)
      vt[i] = {3'b010, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
    vt[10] = {3'b010, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0};
    vt[11] = {3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
    vt[12] = {3'b100, 1'b0, 1'b0, 3'b100, 1'b0, 1'b0, 4'd0};
    vt[13] = {3'b100, 1'b1, 1'b1, 3'b100, 1'b1, 1'b0, 4'd0};
    vt[14] = {3'b001, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 4'd0};
    vt[15] = {3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
    vt[16] = {3'b001, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 4'd1};
    vt[17] = {3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 4'd1};
    vt[18] = {3'b010, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 4'd1};

    #2;

    // ---- 1: reset state and idle refresh cadence ----
    do_reset();
    check("rst_debt", debt, 0);
    check("rst_overflow", overflow, 0);
    check("rst_ref_req", ref_req, 0);
    check("rst_ctl_req", ctl_req, 0);
    check("rst_arb_ack", arb_ack, 0);
    auto_ref = 1'b1; ref_ack = 1'b1;
    while (cyc < 66) begin
      tick();
      check("t1_ref_req", ref_req, (cyc >= 17 && (cyc % 16) == 1) ? 1 : 0);
      check("t1_debt", debt, (cyc >= 16 && ((cyc % 16) == 0 || (cyc % 16) == 1)) ? 1 : 0);
    end

    // ---- 2: client handshake, table driven ----
    do_reset();
    for (int i = 0; i < 19; i++) begin
      arb_req = vt[i].arb; ctl_ack = vt[i].ack; ctl_complete = vt[i].cpl;
      #1;
      check("t2_ctl_req", ctl_req, vt[i].e_ctl);
      check("t2_arb_ack", arb_ack, vt[i].e_aack);
      check("t2_ref_req", ref_req, vt[i].e_ref);
      check("t2_debt", debt, vt[i].e_debt);
      tick();
    end

    // ---- 3: saturating client, urgent refresh takes over between bursts ----
    do_reset();
    auto_ref = 1'b1; ref_ack = 1'b1;
    auto_cli = 1'b1; arb_req = 3'b010;
    #1;
    ctl_ack = |ctl_req;
    #1;
    grants = 0; refs = 0; maxd = 0; ref_since = 1'b0;
    for (int k = 0; k < 700; k++) begin
      if (arb_ack) begin
        grants++;
        check("t3_grant_below_urgent", (debt < 4'd4), 1);
        if (ref_since) check("t3_resume_debt", debt, 3);
        ref_since = 1'b0;
      end
      if (ref_req && ref_ack) begin
        refs++;
        ref_since = 1'b1;
      end
      if (burst_cnt != 0) check("t3_no_ref_in_burst", ref_req, 0);
      if (int'(debt) > maxd) maxd = int'(debt);
      tick();
    end
    check("t3_debt_reached_urgent", (maxd >= 4), 1);
    check("t3_grants", (grants >= 4), 1);
    check("t3_refreshes", (refs >= 3), 1);

    // ---- 4: refresh starved, debt saturates and overflow sticks ----
    do_reset();
    run_to(140);
    check("t4_debt_140", debt, 8);
    check("t4_ovf_140", overflow, 0);
    check("t4_ref_req_140", ref_req, 1);
    run_to(150);
    check("t4_debt_150", debt, 8);
    check("t4_ovf_150", overflow, 1);
    run_to(200);
    auto_ref = 1'b1;
    drained = 1'b0;
    for (int k = 0; k < 300 && !drained; k++) begin
      tick();
      if (debt == 4'd0) drained = 1'b1;
    end
    check("t4_drained", drained, 1);
    check("t4_ovf_after_drain", overflow, 1);
    repeat (20) tick();
    check("t4_ovf_sticky", overflow, 1);

    // ---- 5: credit and refresh accept in the same cycle ----
    do_reset();
    run_to(46);
    check("t5_debt_46", debt, 2);
    check("t5_ref_req_46", ref_req, 1);
    run_to(47);
    ref_ack = 1'b1;
    tick();
    ref_ack = 1'b0;
    check("t5_debt_same", debt, 2);
    check("t5_busy_ref_req", ref_req, 0);
    ref_done = 1'b1;
    tick();
    ref_done = 1'b0;
    check("t5_idle_ref_req", ref_req, 0);
    tick();
    check("t5_rewait_ref_req", ref_req, 1);
    ref_ack = 1'b1;
    tick();
    ref_ack = 1'b0;
    check("t5_debt_dec", debt, 1);

    // ---- 6: async reset mid-XFER and mid-REF_BUSY ----
    do_reset();
    arb_req = 3'b001;
    run_to(2);
    ctl_ack = 1'b1;
    tick();
    ctl_ack = 1'b0;
    #1;
    check("t6_xfer_ctl_req", ctl_req, 0);
    run_to(20);
    check("t6_xfer_debt", debt, 1);
    rst_n = 1'b0; arb_req = 3'b000;
    #1;
    check("t6_xrst_debt", debt, 0);
    check("t6_xrst_ctl_req", ctl_req, 0);
    check("t6_xrst_arb_ack", arb_ack, 0);
    check("t6_xrst_ref_req", ref_req, 0);
    do_reset();
    arb_req = 3'b001;
    #1;
    check("t6_idle_after_rst", ctl_req, 3'b001);
    arb_req = 3'b000;
    #1;
    run_to(33);
    ref_ack = 1'b1;
    tick();
    ref_ack = 1'b0;
    check("t6_busy_debt", debt, 1);
    run_to(36);
    check("t6_busy_hold", debt, 1);
    rst_n = 1'b0;
    #1;
    check("t6_brst_debt", debt, 0);
    check("t6_brst_ref_req", ref_req, 0);
    check("t6_brst_ovf", overflow, 0);
    do_reset();
    auto_ref = 1'b1; ref_ack = 1'b1;
    while (cyc < 20) begin
      tick();
      check("t6_cadence_ref_req", ref_req, (cyc == 17) ? 1 : 0);
      if (cyc == 16) check("t6_cadence_debt", debt, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
